// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential 8-bit reads into a 2-entry prefetch
// buffer, with redirect (jump), halt and a saturating count of issued reads.
module instr_fetch_unit #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_en,
  output logic [7:0]       mem_addr,
  input  logic [7:0]       mem_rdata,
  output logic [7:0]       instr,
  output logic [7:0]       instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             jmp_valid,
  input  logic [7:0]       jmp_target,
  input  logic             halt_req,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned LVL_W = OCC_W + 1;

  if (DEPTH != 2) begin : g_bad_depth
    $error("instr_fetch_unit: DEPTH must be 2");
  end

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] addr;
  } entry_t;

  state_t             state_q, state_d;
  logic [7:0]         pc_q;
  entry_t             buf_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0]   occ_q;
  logic               infl_q;
  logic [7:0]         infl_addr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               pop_c, push_c, issue_c;
  logic [LVL_W-1:0]   level_c;
  entry_t             head_c;

  // Next state and issue decision; a redirect always wins over halt and issue.
  always_comb begin
    state_d = state_q;
    issue_c = 1'b0;
    pop_c   = 1'b0;
    push_c  = 1'b0;
    level_c = '0;
    case (state_q)
      RUN:     if (halt_req && !jmp_valid) state_d = HALTED;
      HALTED:  if (jmp_valid) state_d = RUN;
      default: state_d = RUN;
    endcase
    pop_c   = !rst && (occ_q != '0) && instr_ready;
    push_c  = infl_q && !jmp_valid;
    // Slots already committed (buffered + in flight) once this cycle's pop leaves.
    level_c = LVL_W'(occ_q) + LVL_W'(infl_q) - LVL_W'(pop_c);
    issue_c = !rst && (state_q == RUN) && !halt_req && !jmp_valid
              && (level_c < LVL_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= 8'h00;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      infl_q      <= 1'b0;
      infl_addr_q <= 8'h00;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      infl_q  <= issue_c;
      if (issue_c) infl_addr_q <= pc_q;
      if (jmp_valid)    pc_q <= jmp_target;
      else if (issue_c) pc_q <= pc_q + 8'd1;
      if (issue_c && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
      if (jmp_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        occ_q    <= '0;
      end else begin
        if (push_c)
          wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop_c)
          rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        occ_q <= occ_q + OCC_W'(push_c) - OCC_W'(pop_c);
      end
    end
  end

  // Buffer payload needs no reset: it is only visible while occupancy is nonzero.
  always_ff @(posedge clk) begin
    if (!rst && push_c) buf_q[wr_ptr_q] <= '{data: mem_rdata, addr: infl_addr_q};
  end

  assign head_c      = buf_q[rd_ptr_q];
  assign mem_en      = issue_c;
  assign mem_addr    = rst ? 8'h00 : pc_q;
  assign instr_valid = !rst && (occ_q != '0);
  assign instr       = instr_valid ? head_c.data : 8'h00;
  assign instr_pc    = instr_valid ? head_c.addr : 8'h00;
  assign halted      = !rst && (state_q == HALTED);
  assign fetch_count = cnt_q;

endmodule
